// File: rtl/pc_predict_unit.sv
// Fetch PC register with next-PC prediction from a direct-mapped BTB of 2-bit counters.
// Execute-stage resolutions train the BTB and, on a misprediction, redirect fetch and raise flush.
module pc_predict_unit #(
  parameter int              ADDR_W      = 16,
  parameter int              BTB_ENTRIES = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  output logic              flush
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-2){1'b0}}, 2'b10};

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  r_tag    [BTB_ENTRIES];
  logic [ADDR_W-1:0] r_target [BTB_ENTRIES];
  logic [1:0]        r_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_lk_hit;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic [IDX_W-1:0]  w_res_idx;
  logic [TAG_W-1:0]  w_res_tag;
  logic              w_res_hit;
  logic              w_mispredict;
  logic [ADDR_W-1:0] w_correct_pc;
  logic [ADDR_W-1:0] w_next_pc;

  // Fetch-side lookup sees pre-edge BTB contents; no bypass from a same-cycle update.
  assign w_lk_idx      = r_pc[IDX_W:1];
  assign w_lk_tag      = r_pc[ADDR_W-1:IDX_W+1];
  assign w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
  assign w_pred_target = w_pred_taken ? r_target[w_lk_idx] : (r_pc + PC_STEP);

  assign w_res_idx     = res_pc[IDX_W:1];
  assign w_res_tag     = res_pc[ADDR_W-1:IDX_W+1];
  assign w_res_hit     = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
  assign w_mispredict  = res_valid &&
                         ((res_taken != res_pred_taken) ||
                          (res_taken && (res_target != res_pred_target)));
  assign w_correct_pc  = res_taken ? res_target : (res_pc + PC_STEP);

  assign pc_out      = r_pc;
  assign pred_taken  = w_pred_taken;
  assign pred_target = w_pred_target;
  assign flush       = w_mispredict;

  // A redirect beats stall/halt since those come from squashed wrong-path instructions.
  always_comb begin
    w_next_pc = w_pred_target;
    if (w_mispredict) begin
      w_next_pc = w_correct_pc;
    end else if (stall || halt) begin
      w_next_pc = r_pc;
    end else begin
      w_next_pc = w_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // Training ignores stall/halt: every resolution updates its entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= {ADDR_W{1'b0}};
        r_ctr[i]    <= 2'b01;
      end
    end else if (res_valid) begin
      if (w_res_hit) begin
        if (res_taken) begin
          r_ctr[w_res_idx]    <= ctr_inc(r_ctr[w_res_idx]);
          r_target[w_res_idx] <= res_target;
        end else begin
          r_ctr[w_res_idx]    <= ctr_dec(r_ctr[w_res_idx]);
        end
      end else if (res_taken) begin
        r_valid[w_res_idx]  <= 1'b1;
        r_tag[w_res_idx]    <= w_res_tag;
        r_target[w_res_idx] <= res_target;
        r_ctr[w_res_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: reset, free-run, training, counters, aliasing, stall/halt, wrap, async reset.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] pc_out;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        res_valid = 1'b0;
  logic [15:0] res_pc = 16'h0000;
  logic        res_taken = 1'b0;
  logic [15:0] res_target = 16'h0000;
  logic        res_pred_taken = 1'b0;
  logic [15:0] res_pred_target = 16'h0000;
  logic        flush;

  int n_pass = 0;
  int n_total = 0;

  pc_predict_unit #(.ADDR_W(16), .BTB_ENTRIES(8), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .pc_out(pc_out), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic v, input logic [15:0] p, input logic t,
                           input logic [15:0] tg, input logic pt, input logic [15:0] ptg);
    res_valid = v; res_pc = p; res_taken = t; res_target = tg;
    res_pred_taken = pt; res_pred_target = ptg;
    #1;
  endtask

  // Jump fetch to tgt via a not-taken resolution that was predicted taken; res_pc indexes an unused entry.
  task automatic redirect(input logic [15:0] tgt);
    drive_res(1'b1, tgt - 16'd2, 1'b0, 16'h0000, 1'b1, tgt);
    step();
    res_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    res_valid = 1'b0; res_taken = 1'b1; res_pred_taken = 1'b0;
    step();
    n_total++; if (pc_out !== 16'h0000) $display("FAIL reset_pc got %h want 0000", pc_out); else n_pass++;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken got %b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 16'h0002) $display("FAIL reset_pred_target got %h want 0002", pred_target); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else n_pass++;
    res_taken = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_free_run();
    logic [15:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 16'(2 * i);
      n_total++; if (pc_out !== exp_pc) $display("FAIL freerun_pc[%0d] got %h want %h", i, pc_out, exp_pc); else n_pass++;
      n_total++; if (pred_taken !== 1'b0) $display("FAIL freerun_pred[%0d] got %b want 0", i, pred_taken); else n_pass++;
      step();
    end
  endtask

  task automatic test_train_taken();
    drive_res(1'b1, 16'h0004, 1'b1, 16'h0020, 1'b0, 16'h0006);
    n_total++; if (flush !== 1'b1) $display("FAIL train_flush got %b want 1", flush); else n_pass++;
    step();
    res_valid = 1'b0;
    n_total++; if (pc_out !== 16'h0020) $display("FAIL train_redirect got %h want 0020", pc_out); else n_pass++;
    redirect(16'h0004);
    n_total++; if (pred_taken !== 1'b1) $display("FAIL train_pred_taken got %b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 16'h0020) $display("FAIL train_pred_target got %h want 0020", pred_target); else n_pass++;
    step();
    n_total++; if (pc_out !== 16'h0020) $display("FAIL train_follow got %h want 0020", pc_out); else n_pass++;
  endtask

  task automatic test_ctr_decrement();
    drive_res(1'b1, 16'h0004, 1'b0, 16'h0000, 1'b1, 16'h0020);
    n_total++; if (flush !== 1'b1) $display("FAIL dec1_flush got %b want 1", flush); else n_pass++;
    step();
    n_total++; if (pc_out !== 16'h0006) $display("FAIL dec1_pc got %h want 0006", pc_out); else n_pass++;
    drive_res(1'b1, 16'h0004, 1'b0, 16'h0000, 1'b0, 16'h0006);
    n_total++; if (flush !== 1'b0) $display("FAIL dec2_flush got %b want 0", flush); else n_pass++;
    step();
    res_valid = 1'b0;
    n_total++; if (pc_out !== 16'h0008) $display("FAIL dec2_pc got %h want 0008", pc_out); else n_pass++;
    redirect(16'h0004);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL dec_pred_taken got %b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 16'h0006) $display("FAIL dec_pred_target got %h want 0006", pred_target); else n_pass++;
  endtask

  task automatic test_alias();
    // Counter is at 00: two taken resolutions bring it back to 10.
    for (int i = 0; i < 2; i++) begin
      drive_res(1'b1, 16'h0004, 1'b1, 16'h0020, 1'b0, 16'h0006);
      step();
    end
    res_valid = 1'b0;
    redirect(16'h0004);
    n_total++; if (pred_taken !== 1'b1) $display("FAIL alias_retrain got %b want 1", pred_taken); else n_pass++;
    drive_res(1'b1, 16'h0014, 1'b1, 16'h0100, 1'b0, 16'h0016);
    n_total++; if (flush !== 1'b1) $display("FAIL alias_flush got %b want 1", flush); else n_pass++;
    step();
    res_valid = 1'b0;
    n_total++; if (pc_out !== 16'h0100) $display("FAIL alias_pc got %h want 0100", pc_out); else n_pass++;
    redirect(16'h0004);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL alias_old_miss got %b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 16'h0006) $display("FAIL alias_old_target got %h want 0006", pred_target); else n_pass++;
    redirect(16'h0014);
    n_total++; if (pred_taken !== 1'b1) $display("FAIL alias_new_hit got %b want 1", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 16'h0100) $display("FAIL alias_new_target got %h want 0100", pred_target); else n_pass++;
  endtask

  task automatic test_stall_halt();
    stall = 1'b1;
    drive_res(1'b1, 16'h0030, 1'b1, 16'h0040, 1'b0, 16'h0032);
    n_total++; if (flush !== 1'b1) $display("FAIL stall_flush got %b want 1", flush); else n_pass++;
    step();
    res_valid = 1'b0;
    n_total++; if (pc_out !== 16'h0040) $display("FAIL stall_redirect got %h want 0040", pc_out); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (pc_out !== 16'h0040) $display("FAIL stall_hold[%0d] got %h want 0040", i, pc_out); else n_pass++;
    end
    stall = 1'b0;
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++; if (pc_out !== 16'h0040) $display("FAIL halt_hold[%0d] got %h want 0040", i, pc_out); else n_pass++;
    end
    halt = 1'b0;
    step();
    n_total++; if (pc_out !== 16'h0042) $display("FAIL halt_release got %h want 0042", pc_out); else n_pass++;
  endtask

  task automatic test_wrap();
    redirect(16'hFFFE);
    n_total++; if (pc_out !== 16'hFFFE) $display("FAIL wrap_pc got %h want fffe", pc_out); else n_pass++;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL wrap_pred got %b want 0", pred_taken); else n_pass++;
    n_total++; if (pred_target !== 16'h0000) $display("FAIL wrap_target got %h want 0000", pred_target); else n_pass++;
    step();
    n_total++; if (pc_out !== 16'h0000) $display("FAIL wrap_next got %h want 0000", pc_out); else n_pass++;
  endtask

  task automatic test_async_reset();
    redirect(16'h0014);
    n_total++; if (pred_taken !== 1'b1) $display("FAIL areset_pre_hit got %b want 1", pred_taken); else n_pass++;
    #2;
    rst = 1'b1;
    drive_res(1'b1, 16'h0040, 1'b1, 16'h0080, 1'b0, 16'h0042);
    n_total++; if (pc_out !== 16'h0000) $display("FAIL areset_immediate got %h want 0000", pc_out); else n_pass++;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL areset_btb_clear got %b want 0", pred_taken); else n_pass++;
    step();
    res_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_total++; if (pc_out !== 16'h0000) $display("FAIL areset_release got %h want 0000", pc_out); else n_pass++;
    redirect(16'h0014);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL areset_0014 got %b want 0", pred_taken); else n_pass++;
    redirect(16'h0040);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL areset_discard got %b want 0", pred_taken); else n_pass++;
    redirect(16'h0004);
    n_total++; if (pred_taken !== 1'b0) $display("FAIL areset_0004 got %b want 0", pred_taken); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_train_taken();
    test_ctr_decrement();
    test_alias();
    test_stall_halt();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
